key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 169 ++++++++++++++++
 tb/tb_key_debounce.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Five-channel pushbutton debouncer: 2-flop sync, per-channel FSM, press/release pulses.
// Define KEY_REPEAT_EN to enable auto-repeat presses on up (bit0) and down (bit1).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press,
  output logic [4:0] btn_release
);

  localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                          DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAXV   = (MAX_AB > REPEAT_PERIOD) ?
                          MAX_AB : REPEAT_PERIOD;
  localparam int CW     = $clog2(MAXV + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAXV);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
  localparam logic [4:0]    REP_MASK = 5'b00011;
`endif

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } st_e;

  logic [4:0]    sync1_q;
  logic [4:0]    sync2_q;
  st_e           state_q [5];
  st_e           state_d [5];
  logic [CW-1:0] cnt_q   [5];
  logic [CW-1:0] cnt_d   [5];
  logic [4:0]    press_q;
  logic [4:0]    press_d;
  logic [4:0]    rel_q;
  logic [4:0]    rel_d;

`ifdef KEY_REPEAT_EN
  // Set once the initial repeat delay has elapsed; then the period applies.
  logic [4:0]    rep_q;
  logic [4:0]    rep_d;
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  always_comb begin
`ifdef KEY_REPEAT_EN
    rep_d = rep_q;
`endif
    for (int i = 0; i < 5; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      press_d[i] = 1'b0;
      rel_d[i]   = 1'b0;
      unique case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = PRESS_CHK;
            cnt_d[i]   = '0;
          end
        end
        PRESS_CHK: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
`ifdef KEY_REPEAT_EN
            rep_d[i]   = 1'b0;
`endif
          end else begin
            cnt_d[i] = sat_inc(cnt_q[i]);
          end
        end
        HELD: begin
          if (!sync2_q[i]) begin
            state_d[i] = REL_CHK;
            cnt_d[i]   = '0;
          end
`ifdef KEY_REPEAT_EN
          else if (REP_MASK[i]) begin
            if (cnt_q[i] == (rep_q[i] ? RP_LAST : RD_LAST)) begin
              press_d[i] = 1'b1;
              cnt_d[i]   = '0;
              rep_d[i]   = 1'b1;
            end else begin
              cnt_d[i] = sat_inc(cnt_q[i]);
            end
          end
`endif
        end
        REL_CHK: begin
          if (sync2_q[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
`ifdef KEY_REPEAT_EN
            rep_d[i]   = 1'b0;
`endif
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            rel_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = sat_inc(cnt_q[i]);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
`ifdef KEY_REPEAT_EN
      rep_q   <= '0;
`endif
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      press_q <= press_d;
      rel_q   <= rel_d;
`ifdef KEY_REPEAT_EN
      rep_q   <= rep_d;
`endif
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    btn_level = '0;
    for (int i = 0; i < 5; i++) begin
      btn_level[i] = (state_q[i] == HELD) ||
                     (state_q[i] == REL_CHK);
    end
  end

  assign btn_press   = press_q;
  assign btn_release = rel_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: segment table plus hand sequences, checked by a scoreboard.
// Repeat expectations follow KEY_REPEAT_EN.
module tb_key_debounce;

  localparam int DB  = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int LAT = DB + 2;

  logic       clk;
  logic       rst_n;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [4:0] btn_release;

  key_debounce #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] p;
    logic [4:0] r;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [4:0] m;
    logic [4:0] v;
  } lv_t;

  typedef struct {
    logic [4:0] btn;
    int         dur;
    int         off;
    logic [4:0] p;
    logic [4:0] r;
    bit         chk;
    logic [4:0] lvl;
  } seg_t;

  ev_t  evq[$];
  lv_t  lvq[$];
  seg_t tbl[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;
  bit flushed = 1'b0;

  function automatic void push_ev(int c, logic [4:0] p, logic [4:0] r);
    int  i;
    ev_t e;
    i = 0;
    while (i < evq.size() && evq[i].cyc < c) i++;
    if (i < evq.size() && evq[i].cyc == c) begin
      e = evq[i];
      e.p = e.p | p;
      e.r = e.r | r;
      evq[i] = e;
    end else begin
      e.cyc = c;
      e.p = p;
      e.r = r;
      evq.insert(i, e);
    end
  endfunction

  function automatic void push_lv(int c, logic [4:0] m, logic [4:0] v);
    int  i;
    lv_t l;
    i = 0;
    while (i < lvq.size() && lvq[i].cyc <= c) i++;
    l.cyc = c;
    l.m = m;
    l.v = v;
    lvq.insert(i, l);
  endfunction

  function automatic void add(logic [4:0] b, int d, int o,
                              logic [4:0] p, logic [4:0] r,
                              bit c, logic [4:0] lv);
    seg_t s;
    s.btn = b;
    s.dur = d;
    s.off = o;
    s.p = p;
    s.r = r;
    s.chk = c;
    s.lvl = lv;
    tbl.push_back(s);
  endfunction

  always @(negedge clk) begin
    ev_t e;
    lv_t l;
    if (cyc >= 1) begin
      if (btn_press != 5'b0 || btn_release != 5'b0 ||
          (evq.size() > 0 && evq[0].cyc <= cyc)) begin
        n_tests++;
        if (evq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b, required none",
                   cyc, btn_press, btn_release);
        end else begin
          e = evq.pop_front();
          if (e.cyc != cyc || e.p != btn_press || e.r != btn_release) begin
            n_fail++;
            $display("FAIL pulse cyc=%0d press=%b release=%b, required cyc=%0d press=%b release=%b",
                     cyc, btn_press, btn_release, e.cyc, e.p, e.r);
          end
        end
      end
      while (lvq.size() > 0 && lvq[0].cyc <= cyc) begin
        l = lvq.pop_front();
        n_tests++;
        if (l.cyc != cyc || (btn_level & l.m) != l.v) begin
          n_fail++;
          $display("FAIL level cyc=%0d level&%b=%b, required cyc=%0d value=%b",
                   cyc, l.m, btn_level & l.m, l.cyc, l.v);
        end
      end
      if (done && !flushed) begin
        while (evq.size() > 0) begin
          e = evq.pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL missing_pulse never seen, required cyc=%0d press=%b release=%b",
                   e.cyc, e.p, e.r);
        end
        flushed = 1'b1;
      end
    end
  end

  task automatic wait_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_seg(input seg_t s);
    int n;
    @(posedge clk);
    #1;
    btn_raw = s.btn;
    n = cyc + 1;
    if (s.off >= 0) push_ev(n + s.off, s.p, s.r);
    if (s.chk) push_lv(n + s.dur - 1, 5'h1f, s.lvl);
    repeat (s.dur - 1) @(posedge clk);
  endtask

  task automatic hold_test(input logic [4:0] mask);
    int n;
    int p;
    btn_raw = mask;
    n = cyc + 1;
    p = n + LAT;
    push_ev(p, mask, 5'b0);
    push_lv(p - 1, mask, 5'b0);
    push_lv(p, mask, mask);
`ifdef KEY_REPEAT_EN
    if ((mask & 5'b00011) != 5'b0) begin
      for (int j = 0; j < 5; j++) push_ev(p + RD + RP * j, mask, 5'b0);
    end
`endif
    wait_cyc(p + 55);
    btn_raw = 5'b0;
    push_lv(p + 61, mask, mask);
    push_ev(p + 56 + LAT, 5'b0, mask);
    push_lv(p + 56 + LAT, mask, 5'b0);
    wait_cyc(p + 72);
  endtask

  task automatic reset_case(input logic [4:0] mask, input int k);
    int n;
    btn_raw = mask;
    n = cyc + 1;
    if (k > LAT) push_ev(n + LAT, mask, 5'b0);
    wait_cyc(n + k - 1);
    rst_n = 1'b0;
    push_lv(n + k, 5'h1f, 5'b0);
    wait_cyc(n + k);
    rst_n = 1'b1;
    push_lv(n + k + LAT, mask, 5'b0);
    push_ev(n + k + 1 + LAT, mask, 5'b0);
    push_lv(n + k + 1 + LAT, mask, mask);
    wait_cyc(n + k + 9);
    btn_raw = 5'b0;
    push_ev(n + k + 10 + LAT, 5'b0, mask);
    wait_cyc(n + k + 24);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    btn_raw = 5'b0;
    for (int c = 1; c <= 4; c++) push_lv(c, 5'h1f, 5'b0);
    wait_cyc(3);
    rst_n = 1'b1;

    wait_cyc(9);
    hold_test(5'b00001);
    hold_test(5'b00100);

    add(5'b00010, 2, -1, 5'b0, 5'b0, 1'b0, 5'b0);
    add(5'b00000, 2, -1, 5'b0, 5'b0, 1'b0, 5'b0);
    add(5'b00010, 2, -1, 5'b0, 5'b0, 1'b0, 5'b0);
    add(5'b00000, 20, -1, 5'b0, 5'b0, 1'b1, 5'b00000);
    add(5'b10000, 30, LAT, 5'b10000, 5'b0, 1'b1, 5'b10000);
    add(5'b00000, 1, -1, 5'b0, 5'b0, 1'b0, 5'b0);
    add(5'b10000, 1, -1, 5'b0, 5'b0, 1'b0, 5'b0);
    add(5'b00000, 20, LAT, 5'b0, 5'b10000, 1'b1, 5'b00000);
    add(5'b01001, 12, LAT, 5'b01001, 5'b0, 1'b1, 5'b01001);
    add(5'b00000, 12, LAT, 5'b0, 5'b01001, 1'b1, 5'b00000);
    add(5'b00100, 3, -1, 5'b0, 5'b0, 1'b0, 5'b0);
    add(5'b00000, 10, -1, 5'b0, 5'b0, 1'b1, 5'b00000);
    add(5'b00001, 10, LAT, 5'b00001, 5'b0, 1'b1, 5'b00001);
    add(5'b00011, 10, LAT, 5'b00010, 5'b0, 1'b1, 5'b00011);
    add(5'b00010, 10, LAT, 5'b0, 5'b00001, 1'b1, 5'b00010);
    add(5'b00000, 12, LAT, 5'b0, 5'b00010, 1'b1, 5'b00000);
    add(5'b00100, 12, LAT, 5'b00100, 5'b0, 1'b1, 5'b00100);
    add(5'b01000, 12, LAT, 5'b01000, 5'b00100, 1'b1, 5'b01000);
    add(5'b00000, 12, LAT, 5'b0, 5'b01000, 1'b1, 5'b00000);
    foreach (tbl[i]) apply_seg(tbl[i]);

    @(posedge clk);
    #1;
    reset_case(5'b00001, LAT);
    reset_case(5'b10000, LAT + 3);

    wait_cyc(cyc + 10);
    done = 1'b1;
    for (int w = 0; w < 20 && !flushed; w++) @(negedge clk);
    if (!flushed) begin
      n_tests++;
      n_fail++;
      $display("FAIL flush: scoreboard drain not reached, required drained");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
